// File: rtl/dsp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dsp_pkg                                                         |
// | Desc     : Shared constants, prototype coefficients and helpers for the     |
// |            32-channel polyphase filter bank.                               |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package dsp_pkg;

    localparam int PFB_32_NUM_CHANNELS = 32;
    localparam int PFB_32_NUM_TAPS     = 8;
    localparam int PFB_32_COEF_WIDTH   = 18;
    localparam int PFB_32_NUM_COEFS    = PFB_32_NUM_CHANNELS * PFB_32_NUM_TAPS;

    typedef logic [PFB_32_NUM_COEFS-1:0][PFB_32_COEF_WIDTH-1:0] pfb_32_coef_arr_t;

    // Full-precision accumulator width: sum of 8 products needs 3 guard bits.
    function automatic int pfb_32_acc_width(input int in_width, input int coef_width);
        return in_width + coef_width + 3;
    endfunction

    // Prototype lowpass: symmetric main lobe over taps 3/4, negative sidelobes
    // on taps 1/6, with a per-phase ramp so every channel has distinct weights.
    function automatic pfb_32_coef_arr_t pfb_32_gen_coefs();
        pfb_32_coef_arr_t coefs;
        int tap;
        int chan;
        int base;
        int ramp;
        int value;
        coefs = '0;
        for (int n = 0; n < PFB_32_NUM_COEFS; n++) begin
            tap  = n / PFB_32_NUM_CHANNELS;
            chan = n % PFB_32_NUM_CHANNELS;
            case (tap)
                0, 7:    base = 1200;
                1, 6:    base = -9000;
                2, 5:    base = 40000;
                default: base = 110000;
            endcase
            ramp     = (tap < 4) ? chan : (PFB_32_NUM_CHANNELS - 1 - chan);
            value    = base + ramp * 211;
            coefs[n] = PFB_32_COEF_WIDTH'(value);
        end
        return coefs;
    endfunction

    localparam pfb_32_coef_arr_t PFB_32_COEFS = pfb_32_gen_coefs();

endpackage
`default_nettype wire

// File: rtl/pfb_32_filter_mac.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pfb_32_filter_mac                                               |
// | Desc     : 8-tap multiply, two-level adder tree and round/saturate for one  |
// |            component (I or Q) of the polyphase branch filter.              |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module pfb_32_filter_mac
    import dsp_pkg::*;
#(
    parameter int INPUT_DATA_WIDTH  = 16,
    parameter int COEF_WIDTH        = 18,
    parameter int OUTPUT_DATA_WIDTH = 16
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic                                               i_valid,
    input  logic [PFB_32_NUM_TAPS-1:0][INPUT_DATA_WIDTH-1:0]   i_taps,
    input  logic [PFB_32_NUM_TAPS-1:0][COEF_WIDTH-1:0]         i_coefs,
    output logic [OUTPUT_DATA_WIDTH-1:0]                       o_data,
    output logic                                               o_sat
);

    localparam int c_ACC_WIDTH = pfb_32_acc_width(INPUT_DATA_WIDTH, COEF_WIDTH);
    localparam int c_SHIFT     = COEF_WIDTH - 1;
    localparam int c_PAIRS     = PFB_32_NUM_TAPS / 2;

    localparam logic signed [c_ACC_WIDTH-1:0] c_ROUND =
        c_ACC_WIDTH'(longint'(1) << (COEF_WIDTH - 2));
    localparam logic signed [c_ACC_WIDTH-1:0] c_OUT_MAX =
        c_ACC_WIDTH'((longint'(1) << (OUTPUT_DATA_WIDTH - 1)) - 1);
    localparam logic signed [c_ACC_WIDTH-1:0] c_OUT_MIN = ~c_OUT_MAX;

    logic signed [c_ACC_WIDTH-1:0]  r_prod [PFB_32_NUM_TAPS];
    logic signed [c_ACC_WIDTH-1:0]  r_pair [c_PAIRS];
    logic signed [c_ACC_WIDTH-1:0]  r_sum;
    logic [OUTPUT_DATA_WIDTH-1:0]   r_data;
    logic                           r_sat;

    logic signed [c_ACC_WIDTH-1:0]  w_rounded;
    logic signed [c_ACC_WIDTH-1:0]  w_scaled;
    logic                           w_clip_hi;
    logic                           w_clip_lo;
    logic [OUTPUT_DATA_WIDTH-1:0]   w_sat_data;

    always_comb begin
        w_rounded  = r_sum + c_ROUND;
        w_scaled   = w_rounded >>> c_SHIFT;
        w_clip_hi  = w_scaled > c_OUT_MAX;
        w_clip_lo  = w_scaled < c_OUT_MIN;
        w_sat_data = w_scaled[OUTPUT_DATA_WIDTH-1:0];
        if (w_clip_hi) begin
            w_sat_data = c_OUT_MAX[OUTPUT_DATA_WIDTH-1:0];
        end else if (w_clip_lo) begin
            w_sat_data = c_OUT_MIN[OUTPUT_DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < PFB_32_NUM_TAPS; k++) begin
                r_prod[k] <= '0;
            end
            for (int j = 0; j < c_PAIRS; j++) begin
                r_pair[j] <= '0;
            end
            r_sum  <= '0;
            r_data <= '0;
            r_sat  <= 1'b0;
        end else begin
            // Operands are widened first so the product lands sign-correct in the accumulator width.
            for (int k = 0; k < PFB_32_NUM_TAPS; k++) begin
                r_prod[k] <= c_ACC_WIDTH'($signed(i_taps[k])) * c_ACC_WIDTH'($signed(i_coefs[k]));
            end
            for (int j = 0; j < c_PAIRS; j++) begin
                r_pair[j] <= r_prod[2*j] + r_prod[2*j+1];
            end
            r_sum  <= (r_pair[0] + r_pair[1]) + (r_pair[2] + r_pair[3]);
            r_data <= w_sat_data;
            r_sat  <= i_valid & (w_clip_hi | w_clip_lo);
        end
    end

    assign o_data = r_data;
    assign o_sat  = r_sat;

endmodule
`default_nettype wire

// File: rtl/pfb_32_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pfb_32_filter                                                   |
// | Desc     : 32-channel polyphase FIR branch filter: per-channel tap history, |
// |            same-channel forwarding and I/Q MAC pipelines, latency 6.       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module pfb_32_filter
    import dsp_pkg::*;
#(
    parameter int INPUT_DATA_WIDTH  = 16,
    parameter int COEF_WIDTH        = 18,
    parameter int OUTPUT_DATA_WIDTH = 16
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic                          Input_valid,
    input  logic [4:0]                    Input_channel,
    input  logic [INPUT_DATA_WIDTH-1:0]   Input_i,
    input  logic [INPUT_DATA_WIDTH-1:0]   Input_q,
    output logic                          Output_valid,
    output logic [4:0]                    Output_channel,
    output logic [OUTPUT_DATA_WIDTH-1:0]  Output_i,
    output logic [OUTPUT_DATA_WIDTH-1:0]  Output_q,
    output logic                          Error_saturation
);

    localparam int c_SAMPLE_WIDTH = 2 * INPUT_DATA_WIDTH;
    // The oldest tap falls off on every shift, so only taps 0..6 are ever read back.
    localparam int c_STORED_TAPS  = PFB_32_NUM_TAPS - 1;

    logic [c_SAMPLE_WIDTH-1:0]                       r_hist_mem [c_STORED_TAPS][PFB_32_NUM_CHANNELS];
    logic [PFB_32_NUM_CHANNELS-1:0]                  r_primed;

    logic                                            r_s1_valid;
    logic [4:0]                                      r_s1_channel;
    logic [c_SAMPLE_WIDTH-1:0]                       r_s1_sample;
    logic                                            r_s1_primed;
    logic [c_STORED_TAPS-1:0][c_SAMPLE_WIDTH-1:0]    r_s1_hist;

    logic                                            r_s2_valid;
    logic [4:0]                                      r_s2_channel;
    logic [PFB_32_NUM_TAPS-1:0][c_SAMPLE_WIDTH-1:0]  r_s2_taps;

    logic                                            r_s3_valid, r_s4_valid, r_s5_valid, r_s6_valid;
    logic [4:0]                                      r_s3_channel, r_s4_channel, r_s5_channel, r_s6_channel;

    logic                                            w_s2_fwd;
    logic [c_STORED_TAPS-1:0][c_SAMPLE_WIDTH-1:0]    w_s2_old;
    logic [PFB_32_NUM_TAPS-1:0][c_SAMPLE_WIDTH-1:0]  w_s2_hist;
    logic [PFB_32_NUM_TAPS-1:0][INPUT_DATA_WIDTH-1:0] w_taps_i;
    logic [PFB_32_NUM_TAPS-1:0][INPUT_DATA_WIDTH-1:0] w_taps_q;
    logic [PFB_32_NUM_TAPS-1:0][COEF_WIDTH-1:0]      w_coefs;
    logic                                            w_sat_i;
    logic                                            w_sat_q;

    // Stage 2: the sample one slot ahead on the same channel has not yet
    // landed in memory, so its freshly shifted history is taken from r_s2_taps.
    always_comb begin
        w_s2_fwd  = r_s2_valid && (r_s2_channel == r_s1_channel);
        w_s2_old  = '0;
        w_s2_hist = '0;
        for (int k = 0; k < c_STORED_TAPS; k++) begin
            if (w_s2_fwd) begin
                w_s2_old[k] = r_s2_taps[k];
            end else if (r_s1_primed) begin
                w_s2_old[k] = r_s1_hist[k];
            end
        end
        w_s2_hist[0] = r_s1_sample;
        for (int k = 1; k < PFB_32_NUM_TAPS; k++) begin
            w_s2_hist[k] = w_s2_old[k-1];
        end
    end

    // History storage has no reset; the primed flags mask stale contents instead.
    always_ff @(posedge Clk) begin
        for (int k = 0; k < c_STORED_TAPS; k++) begin
            if (r_s1_valid) begin
                r_hist_mem[k][r_s1_channel] <= w_s2_hist[k];
            end
            r_s1_hist[k] <= r_hist_mem[k][Input_channel];
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_primed     <= '0;
            r_s1_valid   <= 1'b0;
            r_s1_channel <= '0;
            r_s1_sample  <= '0;
            r_s1_primed  <= 1'b0;
            r_s2_valid   <= 1'b0;
            r_s2_channel <= '0;
            r_s2_taps    <= '0;
            r_s3_valid   <= 1'b0;
            r_s3_channel <= '0;
            r_s4_valid   <= 1'b0;
            r_s4_channel <= '0;
            r_s5_valid   <= 1'b0;
            r_s5_channel <= '0;
            r_s6_valid   <= 1'b0;
            r_s6_channel <= '0;
        end else begin
            r_s1_valid   <= Input_valid;
            r_s1_channel <= Input_channel;
            r_s1_sample  <= {Input_i, Input_q};
            r_s1_primed  <= r_primed[Input_channel];
            if (r_s1_valid) begin
                r_primed[r_s1_channel] <= 1'b1;
            end
            r_s2_valid   <= r_s1_valid;
            r_s2_channel <= r_s1_channel;
            r_s2_taps    <= w_s2_hist;
            r_s3_valid   <= r_s2_valid;
            r_s3_channel <= r_s2_channel;
            r_s4_valid   <= r_s3_valid;
            r_s4_channel <= r_s3_channel;
            r_s5_valid   <= r_s4_valid;
            r_s5_channel <= r_s4_channel;
            r_s6_valid   <= r_s5_valid;
            r_s6_channel <= r_s5_channel;
        end
    end

    always_comb begin
        w_taps_i = '0;
        w_taps_q = '0;
        w_coefs  = '0;
        for (int k = 0; k < PFB_32_NUM_TAPS; k++) begin
            w_taps_i[k] = r_s2_taps[k][c_SAMPLE_WIDTH-1 -: INPUT_DATA_WIDTH];
            w_taps_q[k] = r_s2_taps[k][INPUT_DATA_WIDTH-1:0];
            w_coefs[k]  = COEF_WIDTH'($signed(PFB_32_COEFS[{3'(k), r_s2_channel}]));
        end
    end

    pfb_32_filter_mac #(
        .INPUT_DATA_WIDTH  (INPUT_DATA_WIDTH),
        .COEF_WIDTH        (COEF_WIDTH),
        .OUTPUT_DATA_WIDTH (OUTPUT_DATA_WIDTH)
    ) u_mac_i (
        .clk     (Clk),
        .rst     (Rst),
        .i_valid (r_s5_valid),
        .i_taps  (w_taps_i),
        .i_coefs (w_coefs),
        .o_data  (Output_i),
        .o_sat   (w_sat_i)
    );

    pfb_32_filter_mac #(
        .INPUT_DATA_WIDTH  (INPUT_DATA_WIDTH),
        .COEF_WIDTH        (COEF_WIDTH),
        .OUTPUT_DATA_WIDTH (OUTPUT_DATA_WIDTH)
    ) u_mac_q (
        .clk     (Clk),
        .rst     (Rst),
        .i_valid (r_s5_valid),
        .i_taps  (w_taps_q),
        .i_coefs (w_coefs),
        .o_data  (Output_q),
        .o_sat   (w_sat_q)
    );

    assign Output_valid     = r_s6_valid;
    assign Output_channel   = r_s6_channel;
    assign Error_saturation = w_sat_i | w_sat_q;

endmodule
`default_nettype wire

// File: tb/tb_pfb_32_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pfb_32_filter                                                |
// | Desc     : Directed self-checking bench for pfb_32_filter.                 |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_pfb_32_filter;
    import dsp_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Input_valid = 1'b0;
    logic [4:0]  Input_channel = '0;
    logic [15:0] Input_i = '0;
    logic [15:0] Input_q = '0;
    logic        Output_valid;
    logic [4:0]  Output_channel;
    logic [15:0] Output_i;
    logic [15:0] Output_q;
    logic        Error_saturation;

    pfb_32_filter #(
        .INPUT_DATA_WIDTH  (16),
        .COEF_WIDTH        (18),
        .OUTPUT_DATA_WIDTH (16)
    ) dut (
        .Clk              (Clk),
        .Rst              (Rst),
        .Input_valid      (Input_valid),
        .Input_channel    (Input_channel),
        .Input_i          (Input_i),
        .Input_q          (Input_q),
        .Output_valid     (Output_valid),
        .Output_channel   (Output_channel),
        .Output_i         (Output_i),
        .Output_q         (Output_q),
        .Error_saturation (Error_saturation)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int ch;
        int vi;
        int vq;
        bit sat;
        int due;
    } exp_t;

    exp_t exp_q[$];
    int   cap[$];
    bit   cap_en = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_in = 0;
    int   n_out = 0;
    int   n_sat = 0;
    int   hist_i [32][8];
    int   hist_q [32][8];
    int   imp_exp [9] = '{282, -993, 5132, 13882, 14436, 5686, -439, 836, 0};

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic int coef(input int n);
        return int'($signed(PFB_32_COEFS[n]));
    endfunction

    function automatic int scale(input longint acc, output bit sat);
        longint r;
        r = (acc + 65536) >>> 17;
        sat = 1'b0;
        if (r > 32767) begin
            sat = 1'b1;
            return 32767;
        end
        if (r < -32768) begin
            sat = 1'b1;
            return -32768;
        end
        return int'(r);
    endfunction

    task automatic clear_model();
        for (int c = 0; c < 32; c++) begin
            for (int k = 0; k < 8; k++) begin
                hist_i[c][k] = 0;
                hist_q[c][k] = 0;
            end
        end
    endtask

    task automatic send(input int ch, input int vi, input int vq);
        exp_t   e;
        longint ai;
        longint aq;
        bit     si;
        bit     sq;
        for (int k = 7; k > 0; k--) begin
            hist_i[ch][k] = hist_i[ch][k-1];
            hist_q[ch][k] = hist_q[ch][k-1];
        end
        hist_i[ch][0] = vi;
        hist_q[ch][0] = vq;
        ai = 0;
        aq = 0;
        for (int k = 0; k < 8; k++) begin
            ai += longint'(hist_i[ch][k]) * longint'(coef(32*k + ch));
            aq += longint'(hist_q[ch][k]) * longint'(coef(32*k + ch));
        end
        e.ch  = ch;
        e.vi  = scale(ai, si);
        e.vq  = scale(aq, sq);
        e.sat = si | sq;
        e.due = cyc + 6;
        exp_q.push_back(e);
        n_in++;
        Input_valid   = 1'b1;
        Input_channel = 5'(ch);
        Input_i       = 16'(vi);
        Input_q       = 16'(vq);
        @(posedge Clk);
        #1;
        Input_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic impulse_run();
        cap.delete();
        cap_en = 1'b1;
        send(5, 16'sh4000, 0);
        idle(31);
        for (int k = 0; k < 8; k++) begin
            send(5, 0, 0);
            idle(31);
        end
        cap_en = 1'b0;
        checks++;
        assert (cap.size() === 9)
        else begin
            errors++;
            $error("FAIL impulse_count: got %0d expected 9", cap.size());
        end
        for (int k = 0; k < 9 && k < cap.size(); k++) begin
            checks++;
            assert (cap[k] === imp_exp[k])
            else begin
                errors++;
                $error("FAIL impulse_tap%0d: got %0d expected %0d", k, cap[k], imp_exp[k]);
            end
        end
    endtask

    // Output monitor: compares every output slot against the scoreboard head.
    always @(negedge Clk) begin
        if (Rst) begin
            checks++;
            assert ({Output_valid, Output_channel, Output_i, Output_q, Error_saturation} === 39'd0)
            else begin
                errors++;
                $error("FAIL reset_outputs: got v=%0b ch=%0d i=%0d q=%0d sat=%0b expected all 0",
                       Output_valid, Output_channel, Output_i, Output_q, Error_saturation);
            end
        end else if (Output_valid) begin
            n_out++;
            if (Error_saturation) n_sat++;
            if (cap_en && Output_channel == 5'd5) cap.push_back(int'($signed(Output_i)));
            checks++;
            assert (exp_q.size() != 0)
            else begin
                errors++;
                $error("FAIL spurious_output: got valid on ch %0d expected no output", Output_channel);
            end
            if (exp_q.size() != 0) begin
                checks += 5;
                assert (cyc === exp_q[0].due)
                else begin
                    errors++;
                    $error("FAIL latency: got cycle %0d expected %0d", cyc, exp_q[0].due);
                end
                assert (int'(Output_channel) === exp_q[0].ch)
                else begin
                    errors++;
                    $error("FAIL channel: got %0d expected %0d", Output_channel, exp_q[0].ch);
                end
                assert (int'($signed(Output_i)) === exp_q[0].vi)
                else begin
                    errors++;
                    $error("FAIL out_i ch%0d: got %0d expected %0d", exp_q[0].ch, $signed(Output_i), exp_q[0].vi);
                end
                assert (int'($signed(Output_q)) === exp_q[0].vq)
                else begin
                    errors++;
                    $error("FAIL out_q ch%0d: got %0d expected %0d", exp_q[0].ch, $signed(Output_q), exp_q[0].vq);
                end
                assert (Error_saturation === exp_q[0].sat)
                else begin
                    errors++;
                    $error("FAIL sat_flag ch%0d: got %0b expected %0b", exp_q[0].ch, Error_saturation, exp_q[0].sat);
                end
                void'(exp_q.pop_front());
            end
        end else if (exp_q.size() != 0) begin
            checks++;
            assert (exp_q[0].due !== cyc)
            else begin
                errors++;
                $error("FAIL missing_output: got no valid at cycle %0d expected ch %0d", cyc, exp_q[0].ch);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int guard;
        int ch;
        clear_model();

        // Reset held with random input activity
        repeat (10) begin
            Input_valid   = 1'($urandom_range(0, 1));
            Input_channel = 5'($urandom_range(0, 31));
            Input_i       = 16'($urandom);
            Input_q       = 16'($urandom);
            @(posedge Clk);
            #1;
        end
        Input_valid = 1'b0;
        Rst = 1'b0;
        idle(2);

        // Impulse on channel 5
        impulse_run();

        // Back-to-back same channel
        for (int v = 1; v <= 9; v++) send(3, v, -3 * v);
        idle(10);

        // Saturation: full-scale on every channel in demux order
        for (int r = 0; r < 9; r++) begin
            for (int c = 31; c >= 0; c--) send(c, 32767, -32768);
        end
        idle(10);
        checks++;
        assert (n_sat > 0)
        else begin
            errors++;
            $error("FAIL sat_seen: got %0d saturated outputs expected >0", n_sat);
        end

        // Reset in the middle of a 32-channel run
        for (int c = 31; c >= 12; c--) send(c, 1000 + 37 * c, -500 - c);
        Rst = 1'b1;
        n_in -= exp_q.size();
        exp_q.delete();
        clear_model();
        idle(3);
        Rst = 1'b0;
        idle(2);
        impulse_run();

        // Random traffic with gaps, channels 31..0 repeating
        ch = 31;
        for (int n = 0; n < 2048; n++) begin
            send(ch, int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
            ch = (ch == 0) ? 31 : ch - 1;
            idle(int'($urandom_range(0, 3)));
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(posedge Clk);
            guard++;
        end
        #1;
        checks++;
        assert (exp_q.size() === 0)
        else begin
            errors++;
            $error("FAIL drain: got %0d outputs outstanding expected 0", exp_q.size());
        end
        checks++;
        assert (n_out === n_in)
        else begin
            errors++;
            $error("FAIL out_count: got %0d outputs expected %0d", n_out, n_in);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
